rggen_bit_field_w01_event: RTL and testbench

RGGEN_BIT_FIELD_W01_EVENT -- requirements
Module: rggen_bit_field_w01_event

---
 rtl/rggen_rtl_pkg.sv | 46 ++++
 rtl/rggen_bit_field_w01_event_if.sv | 28 ++
 rtl/rggen_edge_detector.sv | 50 +++++
 rtl/rggen_bit_field_w01_event.sv | 118 +++++++++++
 tb/tb_rggen_bit_field_w01_event.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_rtl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rggen_rtl_pkg
//  Brief    : Shared enums and helpers for event-driven W0x/W1x bit fields.
//  Revision : 1.0 - initial release
// ============================================================================
package rggen_rtl_pkg;

  // Software write action applied to a bit whose write data matches the trigger
  typedef enum logic [1:0] {
    RGGEN_W01_SET    = 2'd0,
    RGGEN_W01_CLEAR  = 2'd1,
    RGGEN_W01_TOGGLE = 2'd2
  } rggen_w01_op;

  // Qualification applied to the raw hardware event input
  typedef enum logic [1:0] {
    RGGEN_EVENT_LEVEL = 2'd0,
    RGGEN_EVENT_RISE  = 2'd1,
    RGGEN_EVENT_FALL  = 2'd2,
    RGGEN_EVENT_BOTH  = 2'd3
  } rggen_event_edge;

  // Which side is honoured when software and hardware hit the same bit together
  typedef enum logic {
    RGGEN_SW_WINS = 1'b0,
    RGGEN_HW_WINS = 1'b1
  } rggen_w01_priority;

  // Value the hardware drives a bit to: the opposite sense of the software op.
  // A software set pairs with a hardware clear; clear and toggle pair with set.
  function automatic logic rggen_w01_hw_target(rggen_w01_op op);
    return (op == RGGEN_W01_SET) ? 1'b0 : 1'b1;
  endfunction

  // Value a bit takes when the software action is applied to it
  function automatic logic rggen_w01_sw_value(rggen_w01_op op, logic current);
    case (op)
      RGGEN_W01_SET:   return 1'b1;
      RGGEN_W01_CLEAR: return 1'b0;
      default:         return ~current;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_bit_field_w01_event_if.sv
`default_nettype none
// ============================================================================
//  Module   : rggen_bit_field_w01_event_if
//  Brief    : Register access bundle between a bus bridge and a bit field.
//  Revision : 1.0 - initial release
// ============================================================================
interface rggen_bit_field_w01_event_if #(
  parameter int WIDTH = 1
);
  logic             write_access;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] read_data;

  // Bus side: issues writes, observes the field
  modport master (
    output write_access, write_data, write_mask,
    input  value, read_data
  );

  // Field side: consumes writes, publishes its value
  modport slave (
    input  write_access, write_data, write_mask,
    output value, read_data
  );
endinterface
`default_nettype wire

// File: rtl/rggen_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module   : rggen_edge_detector
//  Brief    : Per-bit event qualifier (level, rising, falling or any edge).
//  Revision : 1.0 - initial release
// ============================================================================
module rggen_edge_detector
  import rggen_rtl_pkg::*;
#(
  parameter int              WIDTH      = 1,
  parameter rggen_event_edge EVENT_EDGE = RGGEN_EVENT_LEVEL
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_hit
);

  generate
    if (EVENT_EDGE == RGGEN_EVENT_LEVEL) begin : g_level
      // Level mode needs no history, so no register is built
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign o_hit          = i_in;
    end else begin : g_edge
      logic [WIDTH-1:0] ev_d;
      logic [WIDTH-1:0] ev_q;

      // Previous-cycle copy of the event input
      always_comb ev_d = i_in;

      // History register clears to 0 so a high input at reset release is an edge
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ev_q <= '0;
        else        ev_q <= ev_d;
      end

      // Compare current and previous sample according to the selected edge
      always_comb begin
        case (EVENT_EDGE)
          RGGEN_EVENT_RISE: o_hit = i_in & ~ev_q;
          RGGEN_EVENT_FALL: o_hit = ~i_in & ev_q;
          default:          o_hit = i_in ^ ev_q;
        endcase
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rggen_bit_field_w01_event.sv
`default_nettype none
// ============================================================================
//  Module   : rggen_bit_field_w01_event
//  Brief    : Event-capturing bit field with W0x/W1x software access,
//             per-bit overflow tracking and a registered interrupt request.
//  Revision : 1.0 - initial release
// ============================================================================
module rggen_bit_field_w01_event
  import rggen_rtl_pkg::*;
#(
  parameter int                WIDTH         = 1,
  parameter logic [WIDTH-1:0]  INITIAL_VALUE = '0,
  parameter rggen_w01_op       SW_OP         = RGGEN_W01_CLEAR,
  parameter logic              TRIGGER_VALUE = 1'b1,
  parameter rggen_event_edge   EVENT_EDGE    = RGGEN_EVENT_LEVEL,
  parameter rggen_w01_priority PRIORITY      = RGGEN_SW_WINS
)(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WIDTH-1:0]                  i_event,
  input  logic [WIDTH-1:0]                  i_irq_mask,
  rggen_bit_field_w01_event_if.slave        bit_field_if,
  output logic [WIDTH-1:0]                  o_value,
  output logic [WIDTH-1:0]                  o_overflow,
  output logic                              o_irq
);

  localparam logic HW_TARGET = rggen_w01_hw_target(SW_OP);

  logic [WIDTH-1:0] event_hit;
  logic [WIDTH-1:0] value_vec;
  logic [WIDTH-1:0] overflow_vec;
  logic [WIDTH-1:0] irq_bits;
  logic             irq_d;
  logic             irq_q;

  rggen_edge_detector #(
    .WIDTH      (WIDTH),
    .EVENT_EDGE (EVENT_EDGE)
  ) u_edge_detector (
    .clk   (clk),
    .rst_n (rst_n),
    .i_in  (i_event),
    .o_hit (event_hit)
  );

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic sw_hit;
      logic hw_hit;
      logic apply_sw;
      logic apply_hw;
      logic sw_value;
      logic value_d;
      logic value_q;
      logic overflow_d;
      logic overflow_q;

      assign sw_hit = bit_field_if.write_access & bit_field_if.write_mask[i] &
                      (bit_field_if.write_data[i] == TRIGGER_VALUE);
      assign hw_hit = event_hit[i];

      // Resolve sw/hw collision, then derive next value and sticky overflow.
      // Overflow sets when an honoured hw hit finds the bit already at target;
      // it clears when an honoured sw action leaves the bit off target.
      always_comb begin
        apply_sw   = sw_hit & (~hw_hit | (PRIORITY == RGGEN_SW_WINS));
        apply_hw   = hw_hit & (~sw_hit | (PRIORITY == RGGEN_HW_WINS));
        sw_value   = rggen_w01_sw_value(SW_OP, value_q);
        value_d    = value_q;
        overflow_d = overflow_q;
        if (apply_sw) begin
          value_d = sw_value;
        end else if (apply_hw) begin
          value_d = HW_TARGET;
        end
        if (apply_sw && (sw_value != HW_TARGET)) begin
          overflow_d = 1'b0;
        end
        if (apply_hw && (value_q == HW_TARGET)) begin
          overflow_d = 1'b1;
        end
      end

      // Per-bit state, reset asynchronously to its initial value
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_q    <= INITIAL_VALUE[i];
          overflow_q <= 1'b0;
        end else begin
          value_q    <= value_d;
          overflow_q <= overflow_d;
        end
      end

      assign value_vec[i]    = value_q;
      assign overflow_vec[i] = overflow_q;
      assign irq_bits[i]     = value_q & i_irq_mask[i];
    end
  endgenerate

  // Any enabled, set bit requests an interrupt on the following cycle
  always_comb irq_d = |irq_bits;

  // Interrupt request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign o_value                = value_vec;
  assign o_overflow             = overflow_vec;
  assign o_irq                  = irq_q;
  assign bit_field_if.value     = value_vec;
  assign bit_field_if.read_data = value_vec;

endmodule
`default_nettype wire

// File: tb/tb_rggen_bit_field_w01_event.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rggen_bit_field_w01_event
//  Brief    : Self-checking bench for rggen_bit_field_w01_event; four field
//             configurations share one stimulus stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rggen_bit_field_w01_event;
  import rggen_rtl_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  // Configuration of each instance: op 0=SET 1=CLEAR 2=TOGGLE,
  // edge 0=LEVEL 1=RISE 2=FALL 3=BOTH, hw_wins 0=SW wins 1=HW wins
  localparam int         CFG_OP   [N] = '{1, 1, 2, 0};
  localparam int         CFG_TRIG [N] = '{1, 1, 0, 1};
  localparam int         CFG_EDGE [N] = '{0, 1, 3, 2};
  localparam int         CFG_HWW  [N] = '{0, 1, 0, 1};
  localparam logic [7:0] CFG_INIT [N] = '{8'h00, 8'h00, 8'h00, 8'hA5};

  logic         clk;
  logic         rst_n;
  logic [W-1:0] ev;
  logic [W-1:0] irqm;
  logic         acc;
  logic [W-1:0] wdata;
  logic [W-1:0] wmask;

  logic [W-1:0] dut_val [N];
  logic [W-1:0] dut_ovf [N];
  logic         dut_irq [N];
  logic [W-1:0] dut_rd  [N];
  logic [W-1:0] dut_ifv [N];

  logic [W-1:0] m_val [N];
  logic [W-1:0] m_ovf [N];
  logic [W-1:0] m_ev  [N];
  logic         m_irq [N];

  int n_checks = 0;
  int n_err    = 0;

  rggen_bit_field_w01_event_if #(.WIDTH(W)) bif0 ();
  rggen_bit_field_w01_event_if #(.WIDTH(W)) bif1 ();
  rggen_bit_field_w01_event_if #(.WIDTH(W)) bif2 ();
  rggen_bit_field_w01_event_if #(.WIDTH(W)) bif3 ();

  assign bif0.write_access = acc;  assign bif0.write_data = wdata;  assign bif0.write_mask = wmask;
  assign bif1.write_access = acc;  assign bif1.write_data = wdata;  assign bif1.write_mask = wmask;
  assign bif2.write_access = acc;  assign bif2.write_data = wdata;  assign bif2.write_mask = wmask;
  assign bif3.write_access = acc;  assign bif3.write_data = wdata;  assign bif3.write_mask = wmask;
  assign dut_rd[0] = bif0.read_data;  assign dut_ifv[0] = bif0.value;
  assign dut_rd[1] = bif1.read_data;  assign dut_ifv[1] = bif1.value;
  assign dut_rd[2] = bif2.read_data;  assign dut_ifv[2] = bif2.value;
  assign dut_rd[3] = bif3.read_data;  assign dut_ifv[3] = bif3.value;

  rggen_bit_field_w01_event #(
    .WIDTH(W), .INITIAL_VALUE(8'h00), .SW_OP(RGGEN_W01_CLEAR), .TRIGGER_VALUE(1'b1),
    .EVENT_EDGE(RGGEN_EVENT_LEVEL), .PRIORITY(RGGEN_SW_WINS)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_event(ev), .i_irq_mask(irqm), .bit_field_if(bif0),
    .o_value(dut_val[0]), .o_overflow(dut_ovf[0]), .o_irq(dut_irq[0])
  );

  rggen_bit_field_w01_event #(
    .WIDTH(W), .INITIAL_VALUE(8'h00), .SW_OP(RGGEN_W01_CLEAR), .TRIGGER_VALUE(1'b1),
    .EVENT_EDGE(RGGEN_EVENT_RISE), .PRIORITY(RGGEN_HW_WINS)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_event(ev), .i_irq_mask(irqm), .bit_field_if(bif1),
    .o_value(dut_val[1]), .o_overflow(dut_ovf[1]), .o_irq(dut_irq[1])
  );

  rggen_bit_field_w01_event #(
    .WIDTH(W), .INITIAL_VALUE(8'h00), .SW_OP(RGGEN_W01_TOGGLE), .TRIGGER_VALUE(1'b0),
    .EVENT_EDGE(RGGEN_EVENT_BOTH), .PRIORITY(RGGEN_SW_WINS)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_event(ev), .i_irq_mask(irqm), .bit_field_if(bif2),
    .o_value(dut_val[2]), .o_overflow(dut_ovf[2]), .o_irq(dut_irq[2])
  );

  rggen_bit_field_w01_event #(
    .WIDTH(W), .INITIAL_VALUE(8'hA5), .SW_OP(RGGEN_W01_SET), .TRIGGER_VALUE(1'b1),
    .EVENT_EDGE(RGGEN_EVENT_FALL), .PRIORITY(RGGEN_HW_WINS)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_event(ev), .i_irq_mask(irqm), .bit_field_if(bif3),
    .o_value(dut_val[3]), .o_overflow(dut_ovf[3]), .o_irq(dut_irq[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_val[k] = CFG_INIT[k];
      m_ovf[k] = '0;
      m_ev[k]  = '0;
      m_irq[k] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural field, evaluated bit by bit from the rules
  task automatic model_step();
    logic [W-1:0] nv, no;
    logic e, p, hw, sw, tgt, swv, cur;
    for (int k = 0; k < N; k++) begin
      nv = m_val[k];
      no = m_ovf[k];
      m_irq[k] = ((m_val[k] & irqm) != '0);
      for (int b = 0; b < W; b++) begin
        e   = ev[b];
        p   = m_ev[k][b];
        cur = m_val[k][b];
        case (CFG_EDGE[k])
          0:       hw = e;
          1:       hw = e && !p;
          2:       hw = !e && p;
          default: hw = (e != p);
        endcase
        sw  = acc && wmask[b] && (int'(wdata[b]) == CFG_TRIG[k]);
        tgt = (CFG_OP[k] == 0) ? 1'b0 : 1'b1;
        swv = (CFG_OP[k] == 0) ? 1'b1 : (CFG_OP[k] == 1) ? 1'b0 : !cur;
        if (sw && (!hw || CFG_HWW[k] == 0)) begin
          nv[b] = swv;
          if (swv != tgt) no[b] = 1'b0;
        end else if (hw) begin
          nv[b] = tgt;
          if (cur == tgt) no[b] = 1'b1;
        end
      end
      m_val[k] = nv;
      m_ovf[k] = no;
      m_ev[k]  = ev;
    end
  endtask

  task automatic check_models(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s d%0d value", tag, k), 64'(dut_val[k]), 64'(m_val[k]));
      check($sformatf("%s d%0d overflow", tag, k), 64'(dut_ovf[k]), 64'(m_ovf[k]));
      check($sformatf("%s d%0d irq", tag, k), 64'(dut_irq[k]), 64'(m_irq[k]));
      check($sformatf("%s d%0d read_data", tag, k), 64'(dut_rd[k]), 64'(m_val[k]));
      check($sformatf("%s d%0d if_value", tag, k), 64'(dut_ifv[k]), 64'(m_val[k]));
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after it
  task automatic cycle(input logic [W-1:0] e, input logic a, input logic [W-1:0] d,
                       input logic [W-1:0] m, input logic [W-1:0] im, input string tag);
    ev = e; acc = a; wdata = d; wmask = m; irqm = im;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_models(tag);
  endtask

  task automatic do_reset(input logic [W-1:0] e);
    ev = e; acc = 1'b0; wdata = '0; wmask = '0; irqm = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] ev;
    logic         acc;
    logic [W-1:0] d;
    logic [W-1:0] m;
    logic [W-1:0] v0;
    logic [W-1:0] o0;
    logic [W-1:0] v1;
    logic [W-1:0] o1;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // inputs, then expected value/overflow of the LEVEL/SW-wins and RISE/HW-wins fields
    tbl[0]  = '{8'h05, 1'b0, 8'h00, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    tbl[1]  = '{8'h00, 1'b1, 8'h01, 8'hFF, 8'h04, 8'h00, 8'h04, 8'h00};
    tbl[2]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    tbl[3]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h05, 8'h01, 8'h05, 8'h00};
    tbl[4]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h05, 8'h01, 8'h05, 8'h00};
    tbl[5]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h05, 8'h01, 8'h05, 8'h00};
    tbl[6]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h05, 8'h01, 8'h05, 8'h00};
    tbl[7]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h05, 8'h01, 8'h05, 8'h01};
    tbl[8]  = '{8'h00, 1'b1, 8'h01, 8'hFF, 8'h04, 8'h00, 8'h04, 8'h00};
    tbl[9]  = '{8'h01, 1'b0, 8'h00, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    tbl[10] = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
    tbl[11] = '{8'h01, 1'b1, 8'h01, 8'hFF, 8'h04, 8'h00, 8'h05, 8'h01};
    tbl[12] = '{8'h00, 1'b1, 8'h04, 8'h00, 8'h04, 8'h00, 8'h05, 8'h01};
    tbl[13] = '{8'h00, 1'b1, 8'hFF, 8'hF0, 8'h04, 8'h00, 8'h05, 8'h01};
    tbl[14] = '{8'h00, 1'b0, 8'hFF, 8'hFF, 8'h04, 8'h00, 8'h05, 8'h01};

    // Reset state
    rst_n = 1'b1;
    ev = '0; acc = 1'b0; wdata = '0; wmask = '0; irqm = '0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset d0 value", 64'(dut_val[0]), 64'h00);
    check("reset d3 value", 64'(dut_val[3]), 64'hA5);
    check("reset d0 irq", 64'(dut_irq[0]), 64'h0);
    check_models("reset");
    do_reset('0);

    // Table-driven vectors
    for (int r = 0; r < 15; r++) begin
      cycle(tbl[r].ev, tbl[r].acc, tbl[r].d, tbl[r].m, 8'h04, $sformatf("tbl%0d", r));
      check($sformatf("tbl%0d d0 value", r), 64'(dut_val[0]), 64'(tbl[r].v0));
      check($sformatf("tbl%0d d0 overflow", r), 64'(dut_ovf[0]), 64'(tbl[r].o0));
      check($sformatf("tbl%0d d1 value", r), 64'(dut_val[1]), 64'(tbl[r].v1));
      check($sformatf("tbl%0d d1 overflow", r), 64'(dut_ovf[1]), 64'(tbl[r].o1));
    end

    // Toggle with zero trigger: value 0x03, write 0xF0 under mask 0x0F
    do_reset('0);
    cycle(8'h03, 1'b0, 8'h00, 8'h00, 8'h04, "tog_setup");
    check("tog_setup d2 value", 64'(dut_val[2]), 64'h03);
    cycle(8'h03, 1'b1, 8'hF0, 8'h0F, 8'h04, "tog_write");
    check("tog_write d2 value", 64'(dut_val[2]), 64'h0C);
    check("tog_write d2 overflow", 64'(dut_ovf[2]), 64'h00);

    // Interrupt follows the value one clock later and drops one clock after unmask
    cycle(8'h04, 1'b0, 8'h00, 8'h00, 8'h04, "irq_n");
    check("irq_n d0 value", 64'(dut_val[0]), 64'h07);
    check("irq_n d0 irq", 64'(dut_irq[0]), 64'h0);
    cycle(8'h00, 1'b0, 8'h00, 8'h00, 8'h04, "irq_n1");
    check("irq_n1 d0 irq", 64'(dut_irq[0]), 64'h1);
    cycle(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, "irq_unmask");
    check("irq_unmask d0 irq", 64'(dut_irq[0]), 64'h0);
    cycle(8'h00, 1'b0, 8'h00, 8'h00, 8'h04, "irq_remask");
    check("irq_remask d0 irq", 64'(dut_irq[0]), 64'h1);

    // Mid-cycle reset acts without a clock edge
    #2;
    ev = 8'h01;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst d0 irq", 64'(dut_irq[0]), 64'h0);
    check("midrst d0 value", 64'(dut_val[0]), 64'h00);
    check("midrst d0 overflow", 64'(dut_ovf[0]), 64'h00);
    check("midrst d3 value", 64'(dut_val[3]), 64'hA5);
    check_models("midrst");

    // Event high at reset release counts as a rising edge
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, "rise_at_release");
    check("rise_at_release d1 value", 64'(dut_val[1]), 64'h01);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      cycle(8'($urandom) & 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
            8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
